// File: rtl/parking_occupancy_ctrl_pkg.sv
// Shared definitions for the gate front end: lane debounce states and lot defaults.
// The door-flashing block imports the same capacity constant.
package parking_occupancy_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } lane_state_e;

  localparam int unsigned CAPACITY_DEFAULT        = 40;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int unsigned CNT_W_DEFAULT           = 6;
  localparam int unsigned DB_W_DEFAULT            = 19;

endpackage

// File: rtl/parking_occupancy_ctrl_sensor_debounce.sv
// One sensor lane: 2-flop synchroniser, debounce FSM with stability counter,
// and a single-cycle registered pulse per accepted rising level.
module sensor_debounce
  import parking_occupancy_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned DB_W            = DB_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse,
  output logic pulse_next
);

  localparam logic [DB_W-1:0] CNT_ZERO = {DB_W{1'b0}};
  localparam logic [DB_W-1:0] CNT_ONE  = {{(DB_W-1){1'b0}}, 1'b1};
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic        sync1_q, sync2_q;
  lane_state_e state_q, state_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic        pulse_q, pulse_d;

  // Next-state logic; the pulse fires on the cycle the rising level is accepted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = RISE_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      RISE_WAIT: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          cnt_d   = CNT_ZERO;
          pulse_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        if (!sync2_q) begin
          state_d = FALL_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      FALL_WAIT: begin
        // A glitch back high during the fall window is not a new vehicle.
        if (sync2_q) begin
          state_d = HIGH;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Synchroniser, FSM state, counter and pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse      = pulse_q;
  assign pulse_next = pulse_d;

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Gate front end: debounces entry/exit loop sensors and keeps a saturating
// occupancy count with full/empty flags and rejection/underflow pulses.
module parking_occupancy_ctrl
  import parking_occupancy_ctrl_pkg::*;
#(
  parameter int unsigned CAPACITY        = CAPACITY_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT,
  parameter int unsigned DB_W            = DB_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_raw,
  input  logic             exit_raw,
  output logic             entry_sensor,
  output logic             exit_sensor,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] occupancy,
  output logic             entry_rejected,
  output logic             underflow_err
);

  localparam logic [CNT_W-1:0] OCC_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] OCC_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] OCC_CAP  = CNT_W'(CAPACITY);

  logic entry_next, exit_next;
  logic inc_s, dec_s;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic full_q, full_d;
  logic empty_q, empty_d;
  logic rej_q, rej_d;
  logic uf_q, uf_d;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W           (DB_W)
  ) u_entry_db (
    .clk       (clk),
    .reset     (reset),
    .raw       (entry_raw),
    .pulse     (entry_sensor),
    .pulse_next(entry_next)
  );

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W           (DB_W)
  ) u_exit_db (
    .clk       (clk),
    .reset     (reset),
    .raw       (exit_raw),
    .pulse     (exit_sensor),
    .pulse_next(exit_next)
  );

  // Occupancy uses the pre-update flags so the count lands with the sensor pulse.
  always_comb begin
    inc_s = entry_next & ~full_q;
    dec_s = exit_next & ~empty_q;
    occ_d = occ_q;
    if (inc_s && dec_s) begin
      occ_d = occ_q;
    end else if (inc_s) begin
      occ_d = occ_q + OCC_ONE;
    end else if (dec_s) begin
      occ_d = occ_q - OCC_ONE;
    end else begin
      occ_d = occ_q;
    end
    full_d  = (occ_d == OCC_CAP);
    empty_d = (occ_d == OCC_ZERO);
    rej_d   = entry_next & full_q;
    uf_d    = exit_next & empty_q;
  end

  // Count, flags and error pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q   <= OCC_ZERO;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      rej_q   <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      rej_q   <= rej_d;
      uf_q    <= uf_d;
    end
  end

  assign occupancy      = occ_q;
  assign full           = full_q;
  assign empty          = empty_q;
  assign entry_rejected = rej_q;
  assign underflow_err  = uf_q;

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Scoreboard bench for parking_occupancy_ctrl with CAPACITY=3, DEBOUNCE_CYCLES=4.
module tb_parking_occupancy_ctrl;

  localparam int CAP = 3;
  localparam int DB  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       entry_raw = 1'b0;
  logic       exit_raw = 1'b0;
  logic       entry_sensor, exit_sensor, full, empty;
  logic [1:0] occupancy;
  logic       entry_rejected, underflow_err;

  typedef struct {
    string nm;
    bit    en;
    bit    ex;
    int    occ;
    bit    fl;
    bit    em;
    bit    rj;
    bit    uf;
    int    cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  parking_occupancy_ctrl #(
    .CAPACITY       (CAP),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (2),
    .DB_W           (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .entry_raw     (entry_raw),
    .exit_raw      (exit_raw),
    .entry_sensor  (entry_sensor),
    .exit_sensor   (exit_sensor),
    .full          (full),
    .empty         (empty),
    .occupancy     (occupancy),
    .entry_rejected(entry_rejected),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every event cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && (entry_sensor || exit_sensor || entry_rejected || underflow_err)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got en=%0b ex=%0b occ=%0d rej=%0b uf=%0b at cyc %0d, required no event",
                 entry_sensor, exit_sensor, occupancy, entry_rejected, underflow_err, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (entry_sensor !== mon_e.en || exit_sensor !== mon_e.ex || int'(occupancy) != mon_e.occ ||
            full !== mon_e.fl || empty !== mon_e.em || entry_rejected !== mon_e.rj ||
            underflow_err !== mon_e.uf || (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
          errors++;
          $display("FAIL %s: got en=%0b ex=%0b occ=%0d full=%0b empty=%0b rej=%0b uf=%0b cyc=%0d, required en=%0b ex=%0b occ=%0d full=%0b empty=%0b rej=%0b uf=%0b cyc=%0d",
                   mon_e.nm, entry_sensor, exit_sensor, occupancy, full, empty, entry_rejected,
                   underflow_err, cyc, mon_e.en, mon_e.ex, mon_e.occ, mon_e.fl, mon_e.em,
                   mon_e.rj, mon_e.uf, mon_e.cyc);
        end
      end
    end
  end

  task automatic expect_ev(string nm, bit en, bit ex, int occ, bit fl, bit em, bit rj, bit uf, int c);
    ev_t e;
    e.nm = nm; e.en = en; e.ex = ex; e.occ = occ; e.fl = fl; e.em = em;
    e.rj = rj; e.uf = uf; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(string nm);
    checks++;
    if ({entry_sensor, exit_sensor, entry_rejected, underflow_err, full, empty, occupancy} !== 8'b0000_0100) begin
      errors++;
      $display("FAIL %s: got en=%0b ex=%0b rej=%0b uf=%0b full=%0b empty=%0b occ=%0d, required 0 0 0 0 0 1 0",
               nm, entry_sensor, exit_sensor, entry_rejected, underflow_err, full, empty, occupancy);
    end
  endtask

  task automatic do_reset(string nm);
    entry_raw = 1'b0;
    exit_raw  = 1'b0;
    reset     = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs(nm);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Holds the selected raw lines high for n cycles, then lets both lanes settle back to IDLE.
  task automatic hold(bit en, bit ex, int n);
    @(negedge clk);
    entry_raw = en;
    exit_raw  = ex;
    repeat (n) @(negedge clk);
    entry_raw = 1'b0;
    exit_raw  = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic drain(string nm);
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending events, required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int k;
    do_reset("reset_state");

    // 1. clean entry with exact latency
    @(negedge clk);
    k = cyc;
    expect_ev("clean_entry", 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, k + DB + 2);
    entry_raw = 1'b1;
    repeat (20) @(negedge clk);
    entry_raw = 1'b0;
    repeat (12) @(negedge clk);
    drain("clean_entry");

    // 2. bounce gives nothing, then one accepted level after a short glitch
    do_reset("reset_before_bounce");
    for (int i = 0; i < 6; i++) begin
      entry_raw = ~entry_raw;
      repeat (2) @(negedge clk);
    end
    entry_raw = 1'b0;
    repeat (12) @(negedge clk);
    expect_ev("bounce_then_clean", 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    entry_raw = 1'b1;
    repeat (3) @(negedge clk);
    entry_raw = 1'b0;
    @(negedge clk);
    entry_raw = 1'b1;
    repeat (10) @(negedge clk);
    entry_raw = 1'b0;
    repeat (12) @(negedge clk);
    drain("bounce_then_clean");

    // 3. fill and reject
    do_reset("reset_before_fill");
    expect_ev("fill_1", 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    hold(1'b1, 1'b0, 8);
    expect_ev("fill_2", 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    hold(1'b1, 1'b0, 8);
    expect_ev("fill_3_full", 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    hold(1'b1, 1'b0, 8);
    expect_ev("entry_rejected_full", 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    hold(1'b1, 1'b0, 8);
    drain("fill");

    // 4. simultaneous events at full and at a middle count
    expect_ev("simul_at_full", 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    hold(1'b1, 1'b1, 8);
    expect_ev("exit_to_1", 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    hold(1'b0, 1'b1, 8);
    expect_ev("simul_at_1", 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    hold(1'b1, 1'b1, 8);
    drain("simul");

    // 5. underflow, then simultaneous at empty
    do_reset("reset_before_underflow");
    expect_ev("underflow", 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    hold(1'b0, 1'b1, 8);
    expect_ev("simul_at_empty", 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    hold(1'b1, 1'b1, 8);
    drain("underflow");

    // 6. async reset mid-debounce with the sensor held through release
    do_reset("reset_before_midop");
    expect_ev("midop_fill_1", 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    hold(1'b1, 1'b0, 8);
    expect_ev("midop_fill_2", 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    hold(1'b1, 1'b0, 8);
    drain("midop_fill");
    @(negedge clk);
    entry_raw = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset_midop");
    repeat (3) @(negedge clk);
    expect_ev("pulse_after_release", 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    entry_raw = 1'b0;
    repeat (12) @(negedge clk);
    drain("after_release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
